// File: rtl/stone_drawer.sv
// stone_drawer: scans the stone RAM each frame and streams a 16x16 sprite per visible entry to the VGA plot port.
// Optional STONE_DRAWER_HIGHLIGHT_EN: moving entries are drawn in white instead of their type colour.
module stone_drawer #(
   parameter int         READ_LATENCY   = 2,
   parameter logic [2:0] COLOUR_STONE   = 3'b101,
   parameter logic [2:0] COLOUR_GOLD    = 3'b110,
   parameter logic [2:0] COLOUR_DIAMOND = 3'b011
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        start,
   input  logic [3:0]  quantity,
   input  logic [31:0] ram_q,
   output logic        draw_flag,
   output logic [3:0]  draw_index,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  vga_colour,
   output logic        vga_plot,
   output logic        done
);
   localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_PLOT, S_NEXT, S_DONE} state_t;
   state_t state_q, state_d;
   logic [3:0]  idx_q, idx_d, qty_q, qty_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [31:0] entry_q, entry_d;
   logic [7:0]  pix_q, pix_d;
   logic [9:0]  sx;
   logic [8:0]  sy;
   logic [2:0]  type_colour, colour;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      qty_d   = qty_q;
      wait_d  = wait_q;
      entry_d = entry_q;
      pix_d   = pix_q;
      case (state_q)
         S_IDLE: if (start) begin
            qty_d   = quantity;
            idx_d   = 4'd0;
            state_d = (quantity == 4'd0) ? S_DONE : S_ADDR;
         end
         S_ADDR: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wait_d  = wait_q + 1'b1;
            state_d = (wait_q == WW'(READ_LATENCY - 1)) ? S_LATCH : S_WAIT;
         end
         S_LATCH: begin
            entry_d = ram_q;
            pix_d   = 8'd0;
            state_d = ram_q[1] ? S_PLOT : S_NEXT;
         end
         S_PLOT: begin
            pix_d   = pix_q + 8'd1;
            state_d = (pix_q == 8'hff) ? S_NEXT : S_PLOT;
         end
         S_NEXT: if ({1'b0, idx_q} + 5'd1 >= {1'b0, qty_q}) state_d = S_DONE;
         else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_ADDR;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   // Pixel outputs are computed from next-state values so they register in step with the PLOT state.
   always_comb begin
      sx = {1'b0, entry_d[31:23]} + {6'd0, pix_d[3:0]};
      sy = {1'b0, entry_d[18:11]} + {5'd0, pix_d[7:4]};
      type_colour = (entry_d[3:2] == 2'b00) ? COLOUR_STONE :
                    (entry_d[3:2] == 2'b01) ? COLOUR_GOLD : COLOUR_DIAMOND;
`ifdef STONE_DRAWER_HIGHLIGHT_EN
      colour = entry_d[0] ? 3'b111 : type_colour;
`else
      colour = type_colour;
`endif
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         idx_q      <= 4'd0;
         qty_q      <= 4'd0;
         wait_q     <= '0;
         entry_q    <= 32'd0;
         pix_q      <= 8'd0;
         draw_flag  <= 1'b0;
         draw_index <= 4'd0;
         vga_x      <= 9'd0;
         vga_y      <= 8'd0;
         vga_colour <= 3'd0;
         vga_plot   <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         qty_q     <= qty_d;
         wait_q    <= wait_d;
         entry_q   <= entry_d;
         pix_q     <= pix_d;
         draw_flag <= (state_d == S_ADDR) || (state_d == S_WAIT) || (state_d == S_LATCH) ||
                      (state_d == S_PLOT) || (state_d == S_NEXT);
         if (state_d == S_ADDR) draw_index <= idx_d;
         if (state_d == S_PLOT) begin
            vga_x      <= sx[8:0];
            vga_y      <= sy[7:0];
            vga_colour <= colour;
         end
         vga_plot  <= (state_d == S_PLOT) && (sx < 10'd320) && (sy < 9'd240);
         done      <= (state_d == S_DONE);
      end
   end
endmodule

// File: tb/tb_stone_drawer.sv
// tb_stone_drawer: directed passes over a modelled 2-cycle-latency stone RAM, checking plots, timing and reset.
module tb_stone_drawer;
   logic        clock = 1'b0, resetn = 1'b0, start = 1'b0;
   logic [3:0]  quantity = 4'd0;
   logic [31:0] ram_q, d1;
   logic        draw_flag, vga_plot, done;
   logic [3:0]  draw_index;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_colour;
   logic [31:0] mem [16];
   logic [2:0]  exp_col [16];
   int checks = 0, failures = 0;
   int plot_cnt, flag_cnt, done_cnt, done_cyc, first_plot_cyc, col_bad, n_idx;
   logic [8:0]  fx, lx;
   logic [7:0]  fy, ly;
   logic [15:0] idx_log;
   logic [3:0]  last_idx;
   stone_drawer dut (
      .clock(clock), .resetn(resetn), .start(start), .quantity(quantity), .ram_q(ram_q),
      .draw_flag(draw_flag), .draw_index(draw_index), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot), .done(done)
   );
   always #5 clock = ~clock;
   always @(posedge clock) begin
      d1    <= mem[draw_index];
      ram_q <= d1;
   end
   function automatic logic [31:0] mk(input int x, input int y, input logic [1:0] t, input logic vis, input logic mov);
      logic [8:0] xx;
      logic [7:0] yy;
      xx = x[8:0];
      yy = y[7:0];
      return {xx, 4'd0, yy, 7'd0, t, vis, mov};
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic clear_stats();
      plot_cnt = 0; flag_cnt = 0; done_cnt = 0; done_cyc = -1; first_plot_cyc = -1;
      col_bad = 0; n_idx = 0; idx_log = 16'd0; last_idx = 4'd0;
      fx = 9'd0; fy = 8'd0; lx = 9'd0; ly = 8'd0;
   endtask
   task automatic sample(input int cyc);
      if (draw_flag) flag_cnt++;
      if (draw_flag && (n_idx == 0 || draw_index != last_idx)) begin
         idx_log  = {idx_log[11:0], draw_index};
         last_idx = draw_index;
         n_idx++;
      end
      if (vga_plot) begin
         if (plot_cnt == 0) begin
            fx = vga_x; fy = vga_y; first_plot_cyc = cyc;
         end
         lx = vga_x; ly = vga_y;
         if (vga_colour !== exp_col[draw_index]) col_bad++;
         plot_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   endtask
   // Cycle 1 is the first cycle after the edge that sees start.
   task automatic run_pass(input logic [3:0] q, input int restart_at);
      clear_stats();
      quantity = q;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      quantity = 4'hf;
      for (int c = 1; c <= 2000; c++) begin
         start = (c == restart_at);
         sample(c);
         if (done) break;
         @(negedge clock);
      end
      start = 1'b0;
      repeat (5) begin
         @(negedge clock);
         sample(0);
      end
   endtask
   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i] = 32'd0;
         exp_col[i] = 3'd0;
      end
      repeat (3) @(negedge clock);
      check("reset_outputs", {draw_flag, draw_index, vga_x, vga_y, vga_colour, vga_plot, done}, 32'd0);
      resetn = 1'b1;
      @(negedge clock);
      mem[0] = mk(100, 50, 2'b01, 1'b1, 1'b0); exp_col[0] = 3'b110;
      run_pass(4'd1, 0);
      check("gold_plots", plot_cnt, 256);
      check("gold_first_x", fx, 100);
      check("gold_first_y", fy, 50);
      check("gold_last_x", lx, 115);
      check("gold_last_y", ly, 65);
      check("gold_colour", col_bad, 0);
      check("gold_flag_cycles", flag_cnt, 261);
      check("gold_done_cycle", done_cyc, 262);
      check("gold_done_count", done_cnt, 1);
      check("gold_first_pixel_cycle", first_plot_cyc, 5);
      mem[0] = mk(10, 10, 2'b01, 1'b1, 1'b0);   exp_col[0] = 3'b110;
      mem[1] = mk(50, 50, 2'b00, 1'b0, 1'b1);   exp_col[1] = 3'b101;
      mem[2] = mk(200, 100, 2'b00, 1'b1, 1'b0); exp_col[2] = 3'b101;
      run_pass(4'd3, 0);
      check("q3_plots", plot_cnt, 512);
      check("q3_first_xy", {fx, fy}, {9'd10, 8'd10});
      check("q3_last_xy", {lx, ly}, {9'd215, 8'd115});
      check("q3_colour", col_bad, 0);
      check("q3_flag_cycles", flag_cnt, 527);
      check("q3_done_cycle", done_cyc, 528);
      check("q3_index_seq", {n_idx[3:0], idx_log[11:0]}, {4'd3, 12'h012});
      mem[0] = mk(310, 230, 2'b10, 1'b1, 1'b0); exp_col[0] = 3'b011;
      run_pass(4'd1, 100);
      check("clip_plots", plot_cnt, 100);
      check("clip_first_xy", {fx, fy}, {9'd310, 8'd230});
      check("clip_last_xy", {lx, ly}, {9'd319, 8'd239});
      check("clip_colour", col_bad, 0);
      check("clip_flag_cycles", flag_cnt, 261);
      check("midpass_start_done_count", done_cnt, 1);
      check("midpass_start_done_cycle", done_cyc, 262);
      run_pass(4'd0, 0);
      check("q0_done_cycle", done_cyc, 1);
      check("q0_flag_cycles", flag_cnt, 0);
      check("q0_plots", plot_cnt, 0);
      check("q0_done_count", done_cnt, 1);
      mem[0] = mk(100, 50, 2'b01, 1'b1, 1'b0); exp_col[0] = 3'b110;
      mem[1] = mk(20, 20, 2'b00, 1'b1, 1'b0);  exp_col[1] = 3'b101;
      clear_stats();
      quantity = 4'd2;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         sample(c);
         if (plot_cnt == 41) break;
         @(negedge clock);
      end
      check("rst_pixel40_reached", plot_cnt, 41);
      check("rst_pixel40_xy", {vga_x, vga_y}, {9'd108, 8'd52});
      resetn = 1'b0;
      @(negedge clock);
      check("rst_outputs_cleared", {draw_flag, draw_index, vga_x, vga_y, vga_colour, vga_plot, done}, 32'd0);
      resetn = 1'b1;
      plot_cnt = 0;
      repeat (20) begin
         @(negedge clock);
         if (vga_plot || draw_flag || done) plot_cnt++;
      end
      check("rst_no_activity", plot_cnt, 0);
      run_pass(4'd2, 0);
      check("rst_redraw_index_seq", {n_idx[3:0], idx_log[7:0]}, {4'd2, 8'h01});
      check("rst_redraw_first_xy", {fx, fy}, {9'd100, 8'd50});
      check("rst_redraw_plots", plot_cnt, 512);
      check("rst_redraw_done_cycle", done_cyc, 523);
      mem[0] = mk(0, 0, 2'b10, 1'b1, 1'b1);
`ifdef STONE_DRAWER_HIGHLIGHT_EN
      exp_col[0] = 3'b111;
`else
      exp_col[0] = 3'b011;
`endif
      run_pass(4'd1, 0);
      check("moving_plots", plot_cnt, 256);
      check("moving_colour", col_bad, 0);
      check("moving_last_xy", {lx, ly}, {9'd15, 8'd15});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
